mips_ctrl: RTL and testbench
============================

// Module: mips_ctrl
// PURPOSE
//   Instruction decoder/control unit for the single-issue MIPS subset core.
//   Decodes Op/Func of the instruction held in IF/ID into one-hot instruction flags
//   and datapath control fields; fully combinational so IF/ID forms PCSrc in the same cycle.
//   Clocked part: sticky illegal-instruction flag for debug/trap logic.
// PARAMETERS
//   none
// PORTS
//   clk       in   1  system clock; only the sticky flag register uses it
//   reset     in   1  asynchronous, active-low reset
//   Op        in   6  instruction bits [31:26]
//   Func      in   6  instruction bits [5:0]
//   R         out  1  Op==6'b000000
//   addu      out  1  R & Func==6'b100001
//   subu      out  1  R & Func==6'b100011
//   jr        out  1  R & Func==6'b001000
//   ori       out  1  Op==6'b001101
//   lw        out  1  Op==6'b100011
//   sw        out  1  Op==6'b101011
//   beq       out  1  Op==6'b000100
//   lui       out  1  Op==6'b001111
//   j         out  1  Op==6'b000010
//   jal       out  1  Op==6'b000011
//   RegDst    out  2  0=rt, 1=rd, 2=$31
//   ALUSrc    out  1  1=extended immediate, 0=rt
//   ALUOp     out  3  0=add, 1=sub, 2=or, 3=lui(imm<<16), others unused
//   ExtOp     out  1  1=sign-extend imm16, 0=zero-extend
//   MemtoReg  out  2  0=ALU, 1=DM, 2=PC+8
//   RegWrite  out  1  GRF write enable
//   MemWrite  out  1  DM write enable
//   PCSrc     out  2  0=PC+4, 1=beq target, 2=j/jal target, 3=jr (GRF[rs])
//   illegal   out  1  combinational: Op/Func match no supported instruction
//   illegal_sticky out 1  registered: set by any cycle with illegal=1
// BEHAVIOUR
//   - All outputs except illegal_sticky combinational from Op/Func; no latency.
//   - At most one of addu,subu,jr,ori,lw,sw,beq,lui,j,jal high; R may accompany addu/subu/jr.
//   - addu: RegDst=1 ALUOp=0 RegWrite=1.  subu: RegDst=1 ALUOp=1 RegWrite=1.
//   - ori: RegDst=0 ALUSrc=1 ALUOp=2 ExtOp=0 RegWrite=1.  lui: ALUSrc=1 ALUOp=3 RegWrite=1.
//   - lw: ALUSrc=1 ALUOp=0 ExtOp=1 MemtoReg=1 RegWrite=1.  sw: ALUSrc=1 ExtOp=1 MemWrite=1.
//   - beq: ALUOp=1 ExtOp=1 PCSrc=1.  j: PCSrc=2.  jal: PCSrc=2 RegDst=2 MemtoReg=2 RegWrite=1.
//   - jr: PCSrc=3, no writes.
//   - Priority for PCSrc: beq->1, j|jal->2, jr->3, else 0.
//   - Fields not listed for an instruction are 0. Illegal encodings: every
//     control/enable output 0 (acts as NOP), illegal=1.
//   - R with unsupported Func: R=1, all other flags 0, illegal=1.
//   - illegal_sticky: async clear to 0 when reset low; at posedge clk with reset
//     high, illegal_sticky <= illegal_sticky | illegal. Never self-clears.
//   - Reset does not affect combinational outputs.
// CONFIGURATION
//   CTRL_NOP_LEGAL_EN defined: Op=0,Func=0 (sll, includes all-zero word) is legal:
//     R=1, all controls 0, illegal=0, sticky not set.
//   Undefined: Op=0,Func=0 is illegal (illegal=1, sets sticky); controls still all 0.
// TESTING
//   - Op=000000 Func=100001 -> addu=1 R=1 RegDst=1 ALUOp=0 RegWrite=1 PCSrc=0 illegal=0.
//   - Op=100011 -> lw=1 ALUSrc=1 ExtOp=1 MemtoReg=1 RegWrite=1; Op=101011 -> sw=1 MemWrite=1 RegWrite=0.
//   - Op=000100/000010/000011, Op=0 Func=001000 -> PCSrc=1/2/2/3; jal also RegDst=2 MemtoReg=2.
//   - Op=111111 -> all controls 0, illegal=1; next posedge illegal_sticky=1; stays 1 afterward.
//   - illegal_sticky=1, pull reset low mid-cycle -> clears immediately without a clock edge.
//   - Op=0 Func=0 -> illegal=0 with CTRL_NOP_LEGAL_EN defined, illegal=1 without it.

Source files
------------

// File: rtl/mips_ctrl.sv
// mips_ctrl: instruction decoder / control unit for the single-issue MIPS subset core.
//
// Decodes Op/Func of the instruction held in IF/ID into one-hot instruction flags
// and datapath control fields. Everything except illegal_sticky is purely
// combinational, so IF/ID can form PCSrc in the same cycle it holds the instruction.
//
// Ports
//   clk            in   system clock (only used by the sticky illegal flag)
//   reset          in   asynchronous active-low reset
//   Op, Func       in   instruction bits [31:26] and [5:0]
//   R              out  Op == 0 (R-type)
//   addu..jal      out  one-hot instruction flags
//   RegDst         out  0=rt, 1=rd, 2=$31
//   ALUSrc         out  1=extended immediate, 0=rt
//   ALUOp          out  0=add, 1=sub, 2=or, 3=lui
//   ExtOp          out  1=sign-extend imm16, 0=zero-extend
//   MemtoReg       out  0=ALU, 1=DM, 2=PC+8
//   RegWrite       out  GRF write enable
//   MemWrite       out  DM write enable
//   PCSrc          out  0=PC+4, 1=beq target, 2=j/jal target, 3=jr
//   illegal        out  encoding matches no supported instruction
//   illegal_sticky out  registered OR of illegal since last reset
//
// Build option
//   CTRL_NOP_LEGAL_EN  when defined, Op=0/Func=0 (sll, covers the all-zero word)
//                      decodes as a legal NOP instead of an illegal encoding.

module mips_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Func,
    output logic       R,
    output logic       addu,
    output logic       subu,
    output logic       jr,
    output logic       ori,
    output logic       lw,
    output logic       sw,
    output logic       beq,
    output logic       lui,
    output logic       j,
    output logic       jal,
    output logic [1:0] RegDst,
    output logic       ALUSrc,
    output logic [2:0] ALUOp,
    output logic       ExtOp,
    output logic [1:0] MemtoReg,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [1:0] PCSrc,
    output logic       illegal,
    output logic       illegal_sticky
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_SLL  = 6'b000000;

    assign R = (Op == OP_R);

    // Instruction flag decode
    always_comb begin
        addu    = 1'b0;
        subu    = 1'b0;
        jr      = 1'b0;
        ori     = 1'b0;
        lw      = 1'b0;
        sw      = 1'b0;
        beq     = 1'b0;
        lui     = 1'b0;
        j       = 1'b0;
        jal     = 1'b0;
        illegal = 1'b0;
        case (Op)
            OP_R: begin
                case (Func)
                    FN_ADDU: addu = 1'b1;
                    FN_SUBU: subu = 1'b1;
                    FN_JR:   jr   = 1'b1;
`ifdef CTRL_NOP_LEGAL_EN
                    FN_SLL:  illegal = 1'b0;
`else
                    FN_SLL:  illegal = 1'b1;
`endif
                    default: illegal = 1'b1;
                endcase
            end
            OP_ORI:  ori = 1'b1;
            OP_LW:   lw  = 1'b1;
            OP_SW:   sw  = 1'b1;
            OP_BEQ:  beq = 1'b1;
            OP_LUI:  lui = 1'b1;
            OP_J:    j   = 1'b1;
            OP_JAL:  jal = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    // Datapath control fields derived from the flags; an illegal encoding has
    // no flag set, so it falls through to all-zero controls (a NOP).
    always_comb begin
        RegDst   = 2'd0;
        ALUSrc   = 1'b0;
        ALUOp    = 3'd0;
        ExtOp    = 1'b0;
        MemtoReg = 2'd0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        PCSrc    = 2'd0;

        if (addu) begin
            RegDst   = 2'd1;
            ALUOp    = 3'd0;
            RegWrite = 1'b1;
        end
        if (subu) begin
            RegDst   = 2'd1;
            ALUOp    = 3'd1;
            RegWrite = 1'b1;
        end
        if (ori) begin
            ALUSrc   = 1'b1;
            ALUOp    = 3'd2;
            RegWrite = 1'b1;
        end
        if (lui) begin
            ALUSrc   = 1'b1;
            ALUOp    = 3'd3;
            RegWrite = 1'b1;
        end
        if (lw) begin
            ALUSrc   = 1'b1;
            ExtOp    = 1'b1;
            MemtoReg = 2'd1;
            RegWrite = 1'b1;
        end
        if (sw) begin
            ALUSrc   = 1'b1;
            ExtOp    = 1'b1;
            MemWrite = 1'b1;
        end
        if (beq) begin
            ALUOp    = 3'd1;
            ExtOp    = 1'b1;
        end
        if (jal) begin
            RegDst   = 2'd2;
            MemtoReg = 2'd2;
            RegWrite = 1'b1;
        end

        if (beq)
            PCSrc = 2'd1;
        else if (j || jal)
            PCSrc = 2'd2;
        else if (jr)
            PCSrc = 2'd3;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            illegal_sticky <= 1'b0;
        else
            illegal_sticky <= illegal_sticky | illegal;
    end

endmodule

// File: tb/tb_mips_ctrl.sv
// tb_mips_ctrl: directed-vector bench for mips_ctrl. Each vector carries a
// hand-written expected control word; the sticky flag is exercised around
// clock edges and an asynchronous reset.

module tb_mips_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] Op;
    logic [5:0] Func;
    logic       R, addu, subu, jr, ori, lw, sw, beq, lui, j, jal;
    logic [1:0] RegDst;
    logic       ALUSrc;
    logic [2:0] ALUOp;
    logic       ExtOp;
    logic [1:0] MemtoReg;
    logic       RegWrite;
    logic       MemWrite;
    logic [1:0] PCSrc;
    logic       illegal;
    logic       illegal_sticky;

    int n_checks = 0;
    int n_fail   = 0;

    mips_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .Op             (Op),
        .Func           (Func),
        .R              (R),
        .addu           (addu),
        .subu           (subu),
        .jr             (jr),
        .ori            (ori),
        .lw             (lw),
        .sw             (sw),
        .beq            (beq),
        .lui            (lui),
        .j              (j),
        .jal            (jal),
        .RegDst         (RegDst),
        .ALUSrc         (ALUSrc),
        .ALUOp          (ALUOp),
        .ExtOp          (ExtOp),
        .MemtoReg       (MemtoReg),
        .RegWrite       (RegWrite),
        .MemWrite       (MemWrite),
        .PCSrc          (PCSrc),
        .illegal        (illegal),
        .illegal_sticky (illegal_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Control word layout: flags{addu,subu,jr,ori,lw,sw,beq,lui,j,jal}, R,
    // RegDst, ALUSrc, ALUOp, ExtOp, MemtoReg, RegWrite, MemWrite, PCSrc, illegal
    function automatic logic [31:0] ctl(input logic [9:0] flags, input logic r,
                                        input logic [1:0] regdst, input logic alusrc,
                                        input logic [2:0] aluop, input logic extop,
                                        input logic [1:0] m2r, input logic rw,
                                        input logic mw, input logic [1:0] pcsrc,
                                        input logic ill);
        return {7'd0, flags, r, regdst, alusrc, aluop, extop, m2r, rw, mw, pcsrc, ill};
    endfunction

    function automatic logic [31:0] observed();
        return {7'd0, addu, subu, jr, ori, lw, sw, beq, lui, j, jal, R,
                RegDst, ALUSrc, ALUOp, ExtOp, MemtoReg, RegWrite, MemWrite, PCSrc, illegal};
    endfunction

    typedef struct {
        string       tag;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

`ifdef CTRL_NOP_LEGAL_EN
    localparam logic NOP_ILL = 1'b0;
`else
    localparam logic NOP_ILL = 1'b1;
`endif

    task automatic apply(input logic [5:0] op, input logic [5:0] fn);
        @(negedge clk);
        Op   = op;
        Func = fn;
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //                 flags          R  RD   AS ALUOp EX M2R RW MW PC   ILL
        vecs.push_back('{"addu",   6'b000000, 6'b100001, ctl(10'b1000000000,1,2'd1,0,3'd0,0,2'd0,1,0,2'd0,0)});
        vecs.push_back('{"subu",   6'b000000, 6'b100011, ctl(10'b0100000000,1,2'd1,0,3'd1,0,2'd0,1,0,2'd0,0)});
        vecs.push_back('{"jr",     6'b000000, 6'b001000, ctl(10'b0010000000,1,2'd0,0,3'd0,0,2'd0,0,0,2'd3,0)});
        vecs.push_back('{"ori",    6'b001101, 6'b100001, ctl(10'b0001000000,0,2'd0,1,3'd2,0,2'd0,1,0,2'd0,0)});
        vecs.push_back('{"lw",     6'b100011, 6'b000000, ctl(10'b0000100000,0,2'd0,1,3'd0,1,2'd1,1,0,2'd0,0)});
        vecs.push_back('{"sw",     6'b101011, 6'b001000, ctl(10'b0000010000,0,2'd0,1,3'd0,1,2'd0,0,1,2'd0,0)});
        vecs.push_back('{"beq",    6'b000100, 6'b111111, ctl(10'b0000001000,0,2'd0,0,3'd1,1,2'd0,0,0,2'd1,0)});
        vecs.push_back('{"lui",    6'b001111, 6'b000000, ctl(10'b0000000100,0,2'd0,1,3'd3,0,2'd0,1,0,2'd0,0)});
        vecs.push_back('{"j",      6'b000010, 6'b000000, ctl(10'b0000000010,0,2'd0,0,3'd0,0,2'd0,0,0,2'd2,0)});
        vecs.push_back('{"jal",    6'b000011, 6'b100011, ctl(10'b0000000001,0,2'd2,0,3'd0,0,2'd2,1,0,2'd2,0)});
        vecs.push_back('{"r_bad",  6'b000000, 6'b100000, ctl(10'b0000000000,1,2'd0,0,3'd0,0,2'd0,0,0,2'd0,1)});

        reset = 1'b0;
        Op    = 6'b000000;
        Func  = 6'b100001;
        #2;
        check("rst_sticky", {31'd0, illegal_sticky}, 32'd0);
        #10;
        reset = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].op, vecs[i].fn);
            check(vecs[i].tag, observed(), vecs[i].exp);
        end
        // r_bad was applied last but has not crossed an edge since; sticky must
        // still be clear, then set at the next edge.
        check("sticky_legal", {31'd0, illegal_sticky}, 32'd0);
        @(posedge clk); #1;
        check("sticky_rbad", {31'd0, illegal_sticky}, 32'd1);

        // Fresh start for the all-ones opcode case.
        reset = 1'b0; #1; reset = 1'b1;
        apply(6'b111111, 6'b101010);
        check("ill_op", observed(), ctl(10'b0,0,2'd0,0,3'd0,0,2'd0,0,0,2'd0,1));
        check("sticky_pre", {31'd0, illegal_sticky}, 32'd0);
        @(posedge clk); #1;
        check("sticky_set", {31'd0, illegal_sticky}, 32'd1);
        apply(6'b100011, 6'b000000);
        repeat (3) @(posedge clk);
        #1;
        check("sticky_hold", {31'd0, illegal_sticky}, 32'd1);

        // Asynchronous clear mid-cycle, away from any edge.
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        check("sticky_async_clr", {31'd0, illegal_sticky}, 32'd0);
        // Combinational decode is not affected by reset.
        Op = 6'b000000; Func = 6'b100001; #1;
        check("addu_in_reset", observed(), ctl(10'b1000000000,1,2'd1,0,3'd0,0,2'd0,1,0,2'd0,0));
        @(negedge clk);
        reset = 1'b1;

        // Op=0/Func=0 legality depends on the build option.
        apply(6'b000000, 6'b000000);
        check("nop_word", observed(), ctl(10'b0,1,2'd0,0,3'd0,0,2'd0,0,0,2'd0,NOP_ILL));
        @(posedge clk); #1;
        check("nop_sticky", {31'd0, illegal_sticky}, {31'd0, NOP_ILL});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
